// File: rtl/alu_decoder_pkg.sv
// Shared constants and types for the MIPS-subset execute front end:
// opcode/funct encodings, alu_op classes and the ALU control enum.
package alu_decoder_pkg;

  localparam int DATA_W = 32;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_NOR,
    ALU_SLT,
    ALU_SLL,
    ALU_SRL
  } alu_ctrl_e;

endpackage

// File: rtl/alu_decoder_alu_core.sv
// Combinational 32-bit ALU: two's-complement add/sub, logic ops,
// signed set-less-than and shamt-driven shifts of the B operand.
module alu_core
  import alu_decoder_pkg::*;
(
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic        [4:0]        shamt,
  input  alu_ctrl_e                ctrl,
  output logic signed [DATA_W-1:0] result,
  output logic                     zero
);

  always_comb begin
    result = a + b;
    case (ctrl)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_NOR: result = ~(a | b);
      ALU_SLT: result = (a < b) ? 32'sd1 : 32'sd0;
      ALU_SLL: result = b << shamt;
      // Go through unsigned so the right shift always zero-fills.
      ALU_SRL: result = $signed($unsigned(b) >> shamt);
      default: result = a + b;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_decoder.sv
// Execute front end: instruction register, field/control decode, immediate
// extension, B-operand mux, ALU control and branch decision.
module alu_decoder
  import alu_decoder_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_en,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [25:0] address,
  output logic [31:0] imm_ext,
  output logic [4:0]  wr_reg,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_dst,
  output logic        alu_src,
  output logic        mem_to_reg,
  output logic        branch,
  output logic        jump,
  output logic [1:0]  alu_op,
  output logic [31:0] alu_out,
  output logic        zero,
  output logic        pc_src
);

  logic [31:0] ir_d, ir_q;
  logic        reg_write_dec;
  logic        funct_bad;
  alu_ctrl_e   alu_ctrl;

  logic signed [DATA_W-1:0] alu_a;
  logic signed [DATA_W-1:0] alu_b;
  logic signed [DATA_W-1:0] alu_res;

  // IR is the only state in the block.
  assign ir_d = instr_en ? instr : ir_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ir_q <= '0;
    else        ir_q <= ir_d;
  end

  assign opcode  = ir_q[31:26];
  assign rs      = ir_q[25:21];
  assign rt      = ir_q[20:16];
  assign rd      = ir_q[15:11];
  assign shamt   = ir_q[10:6];
  assign funct   = ir_q[5:0];
  assign address = ir_q[25:0];

  always_comb begin
    reg_write_dec = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_dst       = 1'b0;
    alu_src       = 1'b0;
    mem_to_reg    = 1'b0;
    branch        = 1'b0;
    jump          = 1'b0;
    alu_op        = ALUOP_ADD;
    // The all-zero word is a NOP even though its opcode field is R-type.
    if (ir_q != '0) begin
      case (opcode)
        OP_RTYPE: begin
          reg_write_dec = 1'b1;
          reg_dst       = 1'b1;
          alu_op        = ALUOP_FUNCT;
        end
        OP_LW: begin
          reg_write_dec = 1'b1;
          mem_read      = 1'b1;
          mem_to_reg    = 1'b1;
          alu_src       = 1'b1;
        end
        OP_SW: begin
          mem_write = 1'b1;
          alu_src   = 1'b1;
        end
        OP_BEQ, OP_BNE: begin
          branch = 1'b1;
          alu_op = ALUOP_SUB;
        end
        OP_ADDI: begin
          reg_write_dec = 1'b1;
          alu_src       = 1'b1;
        end
        OP_ANDI, OP_ORI, OP_SLTI: begin
          reg_write_dec = 1'b1;
          alu_src       = 1'b1;
          alu_op        = ALUOP_IMM;
        end
        OP_J:    jump = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    alu_ctrl  = ALU_ADD;
    funct_bad = 1'b0;
    case (alu_op)
      ALUOP_ADD: alu_ctrl = ALU_ADD;
      ALUOP_SUB: alu_ctrl = ALU_SUB;
      ALUOP_IMM: begin
        case (opcode)
          OP_ANDI: alu_ctrl = ALU_AND;
          OP_ORI:  alu_ctrl = ALU_OR;
          OP_SLTI: alu_ctrl = ALU_SLT;
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      default: begin
        case (funct)
          FN_ADD: alu_ctrl = ALU_ADD;
          FN_SUB: alu_ctrl = ALU_SUB;
          FN_AND: alu_ctrl = ALU_AND;
          FN_OR:  alu_ctrl = ALU_OR;
          FN_NOR: alu_ctrl = ALU_NOR;
          FN_SLT: alu_ctrl = ALU_SLT;
          FN_SLL: alu_ctrl = ALU_SLL;
          FN_SRL: alu_ctrl = ALU_SRL;
          default: begin
            alu_ctrl  = ALU_ADD;
            funct_bad = 1'b1;
          end
        endcase
      end
    endcase
  end

  // An unrecognised R-type function still executes as add but never commits.
  assign reg_write = reg_write_dec & ~funct_bad;
  assign wr_reg    = reg_dst ? rd : rt;

  assign imm_ext = ((opcode == OP_ANDI) || (opcode == OP_ORI))
                   ? {16'h0000, ir_q[15:0]}
                   : {{16{ir_q[15]}}, ir_q[15:0]};

  assign alu_a = rs_data;
  assign alu_b = alu_src ? imm_ext : rt_data;

  alu_core u_alu_core (
    .a      (alu_a),
    .b      (alu_b),
    .shamt  (shamt),
    .ctrl   (alu_ctrl),
    .result (alu_res),
    .zero   (zero)
  );

  assign alu_out = alu_res;
  assign pc_src  = branch & (((opcode == OP_BEQ) & zero) | ((opcode == OP_BNE) & ~zero));

endmodule

// File: tb/tb_alu_decoder.sv
// Bench for alu_decoder: directed vector table, reset/hold sequences and
// randomized instructions checked against an instruction-level model.
module tb_alu_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_en;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [25:0] address;
  logic [31:0] imm_ext;
  logic [4:0]  wr_reg;
  logic        reg_write, mem_read, mem_write, reg_dst, alu_src, mem_to_reg, branch, jump;
  logic [1:0]  alu_op;
  logic [31:0] alu_out;
  logic        zero, pc_src;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_decoder dut (
    .clk(clk), .reset(reset), .instr_en(instr_en), .instr(instr),
    .rs_data(rs_data), .rt_data(rt_data),
    .opcode(opcode), .funct(funct), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .address(address), .imm_ext(imm_ext), .wr_reg(wr_reg),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .reg_dst(reg_dst), .alu_src(alu_src), .mem_to_reg(mem_to_reg),
    .branch(branch), .jump(jump), .alu_op(alu_op),
    .alu_out(alu_out), .zero(zero), .pc_src(pc_src)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] alu;
    logic        zero;
    logic        pc;
    logic [7:0]  ctrl;  // {rw, mr, mw, rdst, asrc, m2r, br, j}
    logic [1:0]  op;
    logic [4:0]  wr;
    logic [31:0] imm;
  } vec_t;

  typedef struct packed {
    logic [31:0] alu;
    logic        zero;
    logic        pc;
    logic [7:0]  ctrl;
    logic [1:0]  op;
    logic [4:0]  wr;
    logic [31:0] imm;
  } exp_t;

  vec_t vecs[19];

  function automatic logic [7:0] ctrl_now();
    return {reg_write, mem_read, mem_write, reg_dst, alu_src, mem_to_reg, branch, jump};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Instruction-level semantics: what each MIPS instruction does to its operands.
  function automatic exp_t model(input logic [31:0] ir, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [5:0]  op  = ir[31:26];
    logic [5:0]  fn  = ir[5:0];
    logic [4:0]  sh  = ir[10:6];
    logic [31:0] sx  = {{16{ir[15]}}, ir[15:0]};
    logic [31:0] zx  = {16'h0, ir[15:0]};
    logic rw = 0, mr = 0, mw = 0, rdst = 0, asrc = 0, m2r = 0, br = 0, jmp = 0;
    e = '0;
    e.alu = a + b;
    if (ir != 32'h0) begin
      case (op)
        6'd0: begin
          rw = 1; rdst = 1; e.op = 2'd2;
          case (fn)
            6'd32: e.alu = a + b;
            6'd34: e.alu = a - b;
            6'd36: e.alu = a & b;
            6'd37: e.alu = a | b;
            6'd39: e.alu = ~(a | b);
            6'd42: e.alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'd0:  e.alu = b << sh;
            6'd2:  e.alu = b >> sh;
            default: begin e.alu = a + b; rw = 0; end
          endcase
        end
        6'd35: begin rw = 1; mr = 1; m2r = 1; asrc = 1; e.alu = a + sx; end
        6'd43: begin mw = 1; asrc = 1; e.alu = a + sx; end
        6'd4, 6'd5: begin br = 1; e.op = 2'd1; e.alu = a - b; end
        6'd8:  begin rw = 1; asrc = 1; e.alu = a + sx; end
        6'd12: begin rw = 1; asrc = 1; e.op = 2'd3; e.alu = a & zx; end
        6'd13: begin rw = 1; asrc = 1; e.op = 2'd3; e.alu = a | zx; end
        6'd10: begin rw = 1; asrc = 1; e.op = 2'd3;
                     e.alu = ($signed(a) < $signed(sx)) ? 32'd1 : 32'd0; end
        6'd2:  jmp = 1;
        default: ;
      endcase
    end
    e.zero = (e.alu == 32'h0);
    e.pc   = (op == 6'd4) ? (a == b) : (op == 6'd5) ? (a != b) : 1'b0;
    e.ctrl = {rw, mr, mw, rdst, asrc, m2r, br, jmp};
    e.wr   = rdst ? ir[15:11] : ir[20:16];
    e.imm  = (op == 6'd12 || op == 6'd13) ? zx : sx;
    return e;
  endfunction

  task automatic load(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    instr = w; instr_en = 1'b1; rs_data = a; rt_data = b;
    @(posedge clk);
    #1 instr_en = 1'b0;
  endtask

  task automatic chk_exp(input string tag, input exp_t e);
    chk({tag, ".alu_out"}, alu_out, e.alu);
    chk({tag, ".zero"},    {31'h0, zero}, {31'h0, e.zero});
    chk({tag, ".pc_src"},  {31'h0, pc_src}, {31'h0, e.pc});
    chk({tag, ".ctrl"},    {24'h0, ctrl_now()}, {24'h0, e.ctrl});
    chk({tag, ".alu_op"},  {30'h0, alu_op}, {30'h0, e.op});
    chk({tag, ".wr_reg"},  {27'h0, wr_reg}, {27'h0, e.wr});
    chk({tag, ".imm_ext"}, imm_ext, e.imm);
  endtask

  logic [5:0]  ops[12] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd5, 6'd8, 6'd12, 6'd13, 6'd10, 6'd2, 6'd0, 6'd63};
  logic [5:0]  fns[8]  = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42, 6'd0, 6'd2};
  logic [31:0] ir_m;
  logic [31:0] snap_alu;
  logic [7:0]  snap_ctrl;
  exp_t        e;

  initial begin
    //                instr         rs            rt            alu        z  pc ctrl        op  wr  imm
    vecs[0]  = '{32'h00222020, 32'd5,        32'd3,        32'd8,        0, 0, 8'b10010000, 2, 4, 32'h00002020};
    vecs[1]  = '{32'h8C23FFFC, 32'h100,      32'h55,       32'hFC,       0, 0, 8'b11001100, 0, 3, 32'hFFFFFFFC};
    vecs[2]  = '{32'h10220003, 32'd7,        32'd7,        32'd0,        1, 1, 8'b00000010, 1, 2, 32'h00000003};
    vecs[3]  = '{32'h14220003, 32'd7,        32'd7,        32'd0,        1, 0, 8'b00000010, 1, 2, 32'h00000003};
    vecs[4]  = '{32'h14220003, 32'd7,        32'd8,        32'hFFFFFFFF, 0, 1, 8'b00000010, 1, 2, 32'h00000003};
    vecs[5]  = '{32'h00022900, 32'h99,       32'd1,        32'd16,       0, 0, 8'b10010000, 2, 5, 32'h00002900};
    vecs[6]  = '{32'h3406FFFF, 32'd0,        32'h1234,     32'h0000FFFF, 0, 0, 8'b10001000, 3, 6, 32'h0000FFFF};
    vecs[7]  = '{32'h0022382A, 32'hFFFFFFFF, 32'd1,        32'd1,        0, 0, 8'b10010000, 2, 7, 32'h0000382A};
    vecs[8]  = '{32'h00222020, 32'h7FFFFFFF, 32'd1,        32'h80000000, 0, 0, 8'b10010000, 2, 4, 32'h00002020};
    vecs[9]  = '{32'h00222021, 32'd5,        32'd3,        32'd8,        0, 0, 8'b00010000, 2, 4, 32'h00002021};
    vecs[10] = '{32'h30228F0F, 32'hFFFFFFFF, 32'd0,        32'h00008F0F, 0, 0, 8'b10001000, 3, 2, 32'h00008F0F};
    vecs[11] = '{32'h08000010, 32'd1,        32'd2,        32'd3,        0, 0, 8'b00000001, 0, 0, 32'h00000010};
    vecs[12] = '{32'h00000000, 32'd4,        32'd6,        32'd10,       0, 0, 8'b00000000, 0, 0, 32'h00000000};
    vecs[13] = '{32'hFC000000, 32'd1,        32'hFFFFFFFF, 32'd0,        1, 0, 8'b00000000, 0, 0, 32'h00000000};
    vecs[14] = '{32'h00222027, 32'hF0F0F0F0, 32'h0F0F0F00, 32'h0000000F, 0, 0, 8'b10010000, 2, 4, 32'h00002027};
    vecs[15] = '{32'h00022902, 32'd0,        32'h80000000, 32'h08000000, 0, 0, 8'b10010000, 2, 5, 32'h00002902};
    vecs[16] = '{32'hAC230008, 32'h10,       32'd9,        32'h18,       0, 0, 8'b00101000, 0, 3, 32'h00000008};
    vecs[17] = '{32'h2822FFFF, 32'hFFFFFFFE, 32'd0,        32'd1,        0, 0, 8'b10001000, 3, 2, 32'hFFFFFFFF};
    vecs[18] = '{32'h2022FFFF, 32'd1,        32'd0,        32'd0,        1, 0, 8'b10001000, 0, 2, 32'hFFFFFFFF};

    reset = 1'b0; instr_en = 1'b0; instr = 32'h8C23FFFC; rs_data = 32'd3; rt_data = 32'd4;
    #2;
    chk("reset.ctrl",    {24'h0, ctrl_now()}, 32'h0);
    chk("reset.alu_op",  {30'h0, alu_op}, 32'h0);
    chk("reset.alu_out", alu_out, 32'd7);
    chk("reset.opcode",  {26'h0, opcode}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 19; i++) begin
      load(vecs[i].instr, vecs[i].rs, vecs[i].rt);
      e = '{vecs[i].alu, vecs[i].zero, vecs[i].pc, vecs[i].ctrl, vecs[i].op, vecs[i].wr, vecs[i].imm};
      chk_exp($sformatf("vec%0d", i), e);
    end

    // Asynchronous reset mid-cycle: controls drop with no clock edge.
    load(32'h8C23FFFC, 32'h100, 32'd2);
    chk("lw.mem_read", {31'h0, mem_read}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst.ctrl",    {24'h0, ctrl_now()}, 32'h0);
    chk("async_rst.alu_out", alu_out, 32'h102);
    chk("async_rst.rt",      {27'h0, rt}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // IR holds while instr_en is low, whatever instr does.
    load(32'h00222022, 32'd10, 32'd4);
    snap_alu = alu_out; snap_ctrl = ctrl_now();
    chk("hold.sub", snap_alu, 32'd6);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      instr = $urandom; instr_en = 1'b0;
      @(posedge clk); #1;
      chk("hold.alu_out", alu_out, snap_alu);
      chk("hold.ctrl",    {24'h0, ctrl_now()}, {24'h0, snap_ctrl});
      chk("hold.funct",   {26'h0, funct}, 32'h22);
    end

    ir_m = 32'h00222022;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      instr = $urandom;
      instr[31:26] = ops[$urandom_range(0, 11)];
      if (instr[31:26] == 6'd0 && $urandom_range(0, 3) != 0) instr[5:0] = fns[$urandom_range(0, 7)];
      if ($urandom_range(0, 19) == 0) instr = 32'h0;
      instr_en = (i == 0) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: rs_data = 32'h7FFFFFFF;
        1: rs_data = 32'h80000000;
        default: rs_data = $urandom;
      endcase
      rt_data = ($urandom_range(0, 3) == 0) ? rs_data : $urandom;
      @(posedge clk);
      if (instr_en) ir_m = instr;
      #1;
      e = model(ir_m, rs_data, rt_data);
      chk_exp($sformatf("rnd%0d", i), e);
      chk($sformatf("rnd%0d.fields", i), {opcode, rs, rt, rd, shamt, funct}, ir_m);
      chk($sformatf("rnd%0d.address", i), {6'h0, address}, {6'h0, ir_m[25:0]});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
